debug_hex_display: RTL and testbench

DEBUG_HEX_DISPLAY -- requirements
Module: debug_hex_display

---
 rtl/debug_hex_display.sv | 143 ++++++++++++++
 tb/tb_debug_hex_display.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/debug_hex_display.sv
// Multi-channel hex debug display with live, capture and auto-scroll views; ch_data->seg_out 2 cycles.
// No backpressure: every channel is sampled or strobed unconditionally each cycle.
module debug_hex_display #(
  parameter int CHANNELS       = 4,
  parameter int DIGITS         = 4,
  parameter int AUTO_PERIOD    = 25_000_000,
  parameter bit BLANK_LZ       = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  localparam int SW            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CHANNELS*DIGITS*4-1:0] ch_data,
  input  logic [CHANNELS-1:0]        ch_valid,
  input  logic [1:0]                 mode,
  input  logic [SW-1:0]              sel,
  input  logic                       freeze,
  output logic [DIGITS*7-1:0]        seg_out,
  output logic [SW-1:0]              ch_idx,
  output logic [7:0]                 hit_cnt
);

  localparam int W  = DIGITS * 4;
  localparam int CW = $clog2(AUTO_PERIOD);
  localparam logic [1:0] M_LIVE = 2'b00;
  localparam logic [1:0] M_CAP  = 2'b01;
  localparam logic [1:0] M_AUTO = 2'b10;
  localparam logic [6:0] SEG_ZERO = SEG_ACTIVE_LOW ? 7'b1000000 : 7'b0111111;
  localparam logic [6:0] SEG_OFF  = SEG_ACTIVE_LOW ? 7'b1111111 : 7'b0000000;

  logic [W-1:0]        cap  [CHANNELS];
  logic [7:0]          hits [CHANNELS];
  logic [CW-1:0]       scroll_cnt;
  logic [1:0]          mode_eff;
  logic [1:0]          mode_q;
  logic [SW-1:0]       sel_ok;
  logic [W-1:0]        disp;
  logic [7:0]          disp_hits;
  logic [DIGITS*7-1:0] seg_nxt;
  logic                nz;
  logic [3:0]          nib;
  logic [6:0]          pat;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b0111111;
      4'h1: hex7 = 7'b0000110;
      4'h2: hex7 = 7'b1011011;
      4'h3: hex7 = 7'b1001111;
      4'h4: hex7 = 7'b1100110;
      4'h5: hex7 = 7'b1101101;
      4'h6: hex7 = 7'b1111101;
      4'h7: hex7 = 7'b0000111;
      4'h8: hex7 = 7'b1111111;
      4'h9: hex7 = 7'b1101111;
      4'hA: hex7 = 7'b1110111;
      4'hB: hex7 = 7'b1111100;
      4'hC: hex7 = 7'b0111001;
      4'hD: hex7 = 7'b1011110;
      4'hE: hex7 = 7'b1111001;
      default: hex7 = 7'b1110001;
    endcase
  endfunction

  assign mode_eff = (mode == 2'b11) ? M_LIVE : mode;
  assign sel_ok   = (32'(sel) < CHANNELS) ? sel : '0;

  // Capture/count decisions use the registered mode so a strobe arriving with a mode change obeys the old mode.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < CHANNELS; k++) begin
        cap[k]  <= '0;
        hits[k] <= '0;
      end
    end else if (!freeze) begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (mode_q != M_CAP || ch_valid[k])
          cap[k] <= ch_data[k*W +: W];
        if (ch_valid[k] && hits[k] != 8'hFF)
          hits[k] <= hits[k] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q     <= M_LIVE;
      scroll_cnt <= '0;
      ch_idx     <= '0;
    end else begin
      mode_q <= mode_eff;
      if (mode_eff != M_AUTO || mode_q != M_AUTO) begin
        scroll_cnt <= '0;
        ch_idx     <= sel_ok;
      end else if (scroll_cnt == CW'(AUTO_PERIOD - 1)) begin
        scroll_cnt <= '0;
        ch_idx     <= (ch_idx == SW'(CHANNELS - 1)) ? '0 : ch_idx + SW'(1);
      end else begin
        scroll_cnt <= scroll_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    disp      = '0;
    disp_hits = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (ch_idx == SW'(k)) begin
        disp      = cap[k];
        disp_hits = hits[k];
      end
    end
  end

  // Walk from the top digit down; nz marks that a nonzero digit has been seen.
  always_comb begin
    seg_nxt = '0;
    nz      = 1'b0;
    nib     = '0;
    pat     = '0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      nib = disp[d*4 +: 4];
      if (nib != 4'h0)
        nz = 1'b1;
      pat = hex7(nib);
      if (BLANK_LZ && !nz && d != 0)
        pat = 7'b0000000;
      seg_nxt[d*7 +: 7] = SEG_ACTIVE_LOW ? ~pat : pat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_cnt <= '0;
      for (int d = 0; d < DIGITS; d++)
        seg_out[d*7 +: 7] <= (d == 0 || !BLANK_LZ) ? SEG_ZERO : SEG_OFF;
    end else begin
      hit_cnt <= disp_hits;
      seg_out <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_debug_hex_display.sv
// Directed bench for debug_hex_display: a 4-channel active-low instance with blanking and fast scroll,
// plus a 3-channel 2-digit instance without blanking for out-of-range select.
module tb_debug_hex_display;

  localparam logic [6:0] S_0 = 7'h40, S_1 = 7'h79, S_2 = 7'h24, S_3 = 7'h30;
  localparam logic [6:0] S_4 = 7'h19, S_5 = 7'h12, S_7 = 7'h78, S_A = 7'h08;
  localparam logic [6:0] S_B = 7'h03, S_C = 7'h46, S_D = 7'h21, S_OFF = 7'h7F;

  logic        clk = 1'b0;
  logic        rst;

  logic [63:0] a_data;
  logic [3:0]  a_valid;
  logic [1:0]  a_mode;
  logic [1:0]  a_sel;
  logic        a_freeze;
  logic [27:0] a_seg;
  logic [1:0]  a_idx;
  logic [7:0]  a_hit;

  logic [23:0] b_data;
  logic [2:0]  b_valid;
  logic [1:0]  b_mode;
  logic [1:0]  b_sel;
  logic        b_freeze;
  logic [13:0] b_seg;
  logic [1:0]  b_idx;
  logic [7:0]  b_hit;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  debug_hex_display #(
    .CHANNELS(4), .DIGITS(4), .AUTO_PERIOD(4), .BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b1)
  ) u_a (
    .clk(clk), .rst(rst), .ch_data(a_data), .ch_valid(a_valid), .mode(a_mode),
    .sel(a_sel), .freeze(a_freeze), .seg_out(a_seg), .ch_idx(a_idx), .hit_cnt(a_hit)
  );

  debug_hex_display #(
    .CHANNELS(3), .DIGITS(2), .AUTO_PERIOD(6), .BLANK_LZ(1'b0), .SEG_ACTIVE_LOW(1'b1)
  ) u_b (
    .clk(clk), .rst(rst), .ch_data(b_data), .ch_valid(b_valid), .mode(b_mode),
    .sel(b_sel), .freeze(b_freeze), .seg_out(b_seg), .ch_idx(b_idx), .hit_cnt(b_hit)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    a_data = '0; a_valid = '0; a_mode = 2'b00; a_sel = '0; a_freeze = 1'b0;
    b_data = '0; b_valid = '0; b_mode = 2'b00; b_sel = '0; b_freeze = 1'b0;
    tick();
    tick();
    chk("rst_a_seg", a_seg, {S_OFF, S_OFF, S_OFF, S_0});
    chk("rst_a_idx", a_idx, 2'd0);
    chk("rst_a_hit", a_hit, 8'd0);
    chk("rst_b_seg", b_seg, {S_0, S_0});
    chk("rst_b_idx", b_idx, 2'd0);

    // Live mode: channel 2 = 00A5, plus out-of-range select on the 3-channel instance.
    rst = 1'b1;
    a_sel = 2'd2;
    a_data = {16'h0000, 16'h00A5, 16'h1234, 16'hBEEF};
    b_sel = 2'd3;
    b_data = {8'h22, 8'h11, 8'h07};
    tick();
    chk("live_lat1_seg", a_seg, {S_OFF, S_OFF, S_OFF, S_0});
    tick();
    chk("live_a5_seg", a_seg, {S_OFF, S_OFF, S_A, S_5});
    chk("live_idx", a_idx, 2'd2);
    chk("live_hit", a_hit, 8'd0);
    chk("oor_b_idx", b_idx, 2'd0);
    chk("oor_b_seg", b_seg, {S_0, S_7});
    b_sel = 2'd2;
    a_data[47:32] = 16'h0705;
    tick();
    tick();
    chk("live_0705_seg", a_seg, {S_OFF, S_7, S_0, S_5});
    chk("b_sel2_seg", b_seg, {S_2, S_2});
    chk("b_sel2_idx", b_idx, 2'd2);

    // Capture mode: only the strobed value 1234 is kept.
    a_sel = 2'd1;
    a_data[31:16] = 16'h9999;
    tick();
    a_mode = 2'b01;
    tick();
    a_data[31:16] = 16'h1234;
    a_valid = 4'b0010;
    tick();
    a_valid = 4'b0000;
    a_data[31:16] = 16'h5678;
    tick();
    tick();
    tick();
    chk("cap_seg", a_seg, {S_1, S_2, S_3, S_4});
    chk("cap_hit", a_hit, 8'd1);
    chk("cap_idx", a_idx, 2'd1);

    // Mode change to live in the same cycle as new data: that edge still obeys capture mode.
    a_data[31:16] = 16'hABCD;
    a_mode = 2'b00;
    tick();
    tick();
    chk("modechg_old_seg", a_seg, {S_1, S_2, S_3, S_4});
    tick();
    chk("modechg_new_seg", a_seg, {S_A, S_B, S_C, S_D});

    // Freeze holds capture registers and counters.
    a_freeze = 1'b1;
    a_valid = 4'b0010;
    a_data[31:16] = 16'h5555;
    tick();
    tick();
    tick();
    chk("frz_seg", a_seg, {S_A, S_B, S_C, S_D});
    chk("frz_hit", a_hit, 8'd1);
    a_freeze = 1'b0;
    a_valid = 4'b0000;
    tick();
    tick();
    chk("unfrz_seg", a_seg, {S_5, S_5, S_5, S_5});

    // Saturating hit counter on channel 0.
    a_sel = 2'd0;
    a_valid = 4'b0001;
    repeat (10) tick();
    chk("sat_cnt9", a_hit, 8'd9);
    repeat (290) tick();
    chk("sat_255", a_hit, 8'd255);
    repeat (5) tick();
    chk("sat_hold", a_hit, 8'd255);
    a_valid = 4'b0000;

    // Auto-scroll with period 4, starting at sel=3; freeze must not stop stepping.
    a_sel = 2'd3;
    a_mode = 2'b10;
    tick();
    chk("auto_enter", a_idx, 2'd3);
    repeat (3) tick();
    chk("auto_hold3", a_idx, 2'd3);
    tick();
    chk("auto_wrap0", a_idx, 2'd0);
    a_freeze = 1'b1;
    repeat (4) tick();
    chk("auto_frz1", a_idx, 2'd1);
    repeat (4) tick();
    chk("auto_2", a_idx, 2'd2);

    // Reset mid-scroll.
    rst = 1'b0;
    tick();
    chk("midrst_idx", a_idx, 2'd0);
    chk("midrst_hit", a_hit, 8'd0);
    chk("midrst_seg", a_seg, {S_OFF, S_OFF, S_OFF, S_0});
    rst = 1'b1;
    tick();
    chk("resume_idx", a_idx, 2'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
